udp_md_parser: RTL and testbench
================================

// Module: udp_md_parser
// PURPOSE
//  Parametrised market-data UDP parser between the MAC byte stream and the NPU.
//  - Validates EtherType, IP protocol and UDP destination port per packet.
//  - Extracts a symbol/price pair at a configurable payload offset.
//  - Matches the symbol against a runtime-programmable table of NUM_SYM targets.
//  - Emits a saturated price tagged with the matching table index; counts dropped packets.
// PARAMETERS
//  NUM_SYM      4       number of target-symbol table entries (1..16)
//  SYM_BYTES    4       symbol field length in bytes (1..8)
//  PRICE_BYTES  4       price field length in bytes, big-endian (1..4)
//  PRICE_OUT_W  8       output price width; must be <= 8*PRICE_BYTES
//  PAYLOAD_OFS  42      byte index of the first symbol byte (frame byte 0 = dst MAC)
//  UDP_DPORT    16'd5000  accepted UDP destination port
// PORTS
//  clk            in   1                        clock
//  rst_n          in   1                        reset, asynchronous, active-low
//  s_axis_tdata   in   8                        frame byte
//  s_axis_tvalid  in   1                        byte valid
//  s_axis_tlast   in   1                        last byte of frame
//  s_axis_tready  out  1                        constant 1 out of reset (never backpressures)
//  cfg_wr         in   1                        table write strobe
//  cfg_idx        in   $clog2(NUM_SYM)          table entry to write
//  cfg_sym        in   8*SYM_BYTES              symbol value to store
//  cfg_en         in   1                        entry enable to store
//  price_out      out  PRICE_OUT_W              extracted price; held until next valid
//  price_idx      out  $clog2(NUM_SYM)          table index of the matched symbol
//  price_valid    out  1                        1-cycle pulse, new price
//  drop_cnt       out  16                       packets rejected; saturates at 0xFFFF
// BEHAVIOUR
//  Reset values: all outputs 0, except s_axis_tready = 0 during reset; table entries 0, disabled.
//  Byte count
//  - 16-bit counter advances only on tvalid; tvalid low stalls every state.
//  - tlast returns the FSM to S_HDR with count 0 on the next cycle.
//  FSM states
//  - S_HDR: check byte12..13 == 0x0800, byte23 == 0x11, byte36..37 == UDP_DPORT.
//    Any mismatch -> S_DROP. Count reaching PAYLOAD_OFS -> S_SYM.
//  - S_SYM: shift SYM_BYTES bytes into sym_sr, MSB first. Then -> S_PRICE.
//  - S_PRICE: shift PRICE_BYTES bytes into price_sr, MSB first.
//    On the last price byte, the full price includes the current tdata.
//    Then -> S_DROP to drain the rest of the frame.
//  - S_DROP: ignore bytes until tlast.
//  Drop counting
//  - tlast in S_HDR/S_SYM/S_PRICE before the last price byte is a short frame:
//    drop_cnt +1, no output.
//  - A header mismatch increments drop_cnt once per frame.
//  Match
//  - Compared on the last price byte: lowest enabled index whose entry == sym_sr wins.
//  - No match -> no output, not counted as a drop.
//  Output
//  - price_valid, price_out and price_idx register 1 cycle after the last price byte is accepted.
//  Saturation
//  - If any price bits above PRICE_OUT_W-1 are set, price_out = all ones.
//  - Otherwise price_out = low PRICE_OUT_W bits.
//  Config
//  - cfg_wr takes effect the next cycle.
//  - A write coinciding with a compare uses the old entry.
//  Boundaries
//  - Last price byte together with tlast: valid output, no drop.
//  - A frame starting the cycle after tlast is parsed normally.
//  Reset mid-frame: FSM to S_HDR; the remaining bytes are parsed as a new frame.
//    That frame fails the header checks and is counted as a drop.
// STRUCTURE
//  md_pkg holds:
//  - typedef enum {S_HDR, S_SYM, S_PRICE, S_DROP} parse_state_t
//  - localparams ETH_TYPE_OFS=12, IP_PROTO_OFS=23, UDP_DPORT_OFS=36, ETHERTYPE_IPV4, PROTO_UDP
//  Sub-module udp_sym_cam:
//  - NUM_SYM-entry register table with write port.
//  - Combinational priority match giving hit + index.
// TESTING
//  1. Valid frame, port 5000, sym "TSLA" in entry 2, price 0x0000002A
//     -> price_valid 1 cycle after byte 49, price_out 0x2A, price_idx 2.
//  2. Same frame, price 0x00000300 -> price_out 0xFF (saturated).
//  3. Port 5001, or EtherType 0x86DD -> no valid, drop_cnt +1.
//  4. tlast at byte 47 -> no valid, drop_cnt +1; next good frame back-to-back is parsed correctly.
//  5. tvalid gaps of 3 cycles inside the price field -> same result as scenario 1.
//     "TSLA" in entries 1 and 3 -> price_idx 1.
//  6. cfg_wr disabling entry 2 on the cycle of byte 49 -> output still produced;
//     the next frame produces no output.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : md_pkg                                                    |
// | Brief  : Shared types, header offsets and header byte check for    |
// |          the market-data UDP parser.                               |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package md_pkg;

   typedef enum logic [1:0] {
      S_HDR   = 2'd0,
      S_SYM   = 2'd1,
      S_PRICE = 2'd2,
      S_DROP  = 2'd3
   } parse_state_t;

   localparam int          ETH_TYPE_OFS   = 12;
   localparam int          IP_PROTO_OFS   = 23;
   localparam int          UDP_DPORT_OFS  = 36;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  PROTO_UDP      = 8'h11;

   // Returns 0 when the byte at frame position cnt contradicts a required
   // header field; positions outside the checked fields always pass.
   function automatic logic hdr_byte_ok(input logic [15:0] cnt,
                                        input logic [7:0]  data,
                                        input logic [15:0] dport);
      logic ok;
      ok = 1'b1;
      case (cnt)
         16'(ETH_TYPE_OFS):      ok = (data == ETHERTYPE_IPV4[15:8]);
         16'(ETH_TYPE_OFS + 1):  ok = (data == ETHERTYPE_IPV4[7:0]);
         16'(IP_PROTO_OFS):      ok = (data == PROTO_UDP);
         16'(UDP_DPORT_OFS):     ok = (data == dport[15:8]);
         16'(UDP_DPORT_OFS + 1): ok = (data == dport[7:0]);
         default:                ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/udp_md_parser_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : udp_md_parser_if                                          |
// | Brief  : Byte-wide AXI-Stream link from the MAC into the parser.   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface udp_md_parser_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tready;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/udp_sym_cam.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : udp_sym_cam                                               |
// | Brief  : Programmable target-symbol table with priority match;     |
// |          the lowest enabled matching entry wins.                   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module udp_sym_cam
   import md_pkg::*;
#(
   parameter int NUM_SYM   = 4,
   parameter int SYM_BYTES = 4,
   parameter int IDX_W     = 2
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic                   cfg_wr,
   input  wire logic [IDX_W-1:0]       cfg_idx,
   input  wire logic [8*SYM_BYTES-1:0] cfg_sym,
   input  wire logic                   cfg_en,
   input  wire logic [8*SYM_BYTES-1:0] key,
   output logic                        hit,
   output logic [IDX_W-1:0]            hit_idx
);

   logic [8*SYM_BYTES-1:0] r_sym [NUM_SYM];
   logic [NUM_SYM-1:0]     r_en;

   // Table storage; a write lands on the next edge so a same-cycle compare sees the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SYM; i++) begin
            r_sym[i] <= '0;
            r_en[i]  <= 1'b0;
         end
      end else if (cfg_wr) begin
         for (int i = 0; i < NUM_SYM; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               r_sym[i] <= cfg_sym;
               r_en[i]  <= cfg_en;
            end
         end
      end
   end

   // Priority match: scanning downwards lets the lowest matching index overwrite last.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SYM - 1; i >= 0; i--) begin
         if (r_en[i] && (r_sym[i] == key)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/udp_md_parser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : udp_md_parser                                             |
// | Brief  : Market-data UDP parser: header validation, symbol/price   |
// |          extraction, symbol table match, saturated price output    |
// |          and dropped-packet counting.                              |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module udp_md_parser
   import md_pkg::*;
#(
   parameter int          NUM_SYM     = 4,
   parameter int          SYM_BYTES   = 4,
   parameter int          PRICE_BYTES = 4,
   parameter int          PRICE_OUT_W = 8,
   parameter int          PAYLOAD_OFS = 42,
   parameter logic [15:0] UDP_DPORT   = 16'd5000,
   localparam int         IDX_W       = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   udp_md_parser_if.slave              s_axis,
   input  wire logic                   cfg_wr,
   input  wire logic [IDX_W-1:0]       cfg_idx,
   input  wire logic [8*SYM_BYTES-1:0] cfg_sym,
   input  wire logic                   cfg_en,
   output logic [PRICE_OUT_W-1:0]      price_out,
   output logic [IDX_W-1:0]            price_idx,
   output logic                        price_valid,
   output logic [15:0]                 drop_cnt
);

   localparam int c_sw         = 8 * SYM_BYTES;
   localparam int c_pw         = 8 * PRICE_BYTES;
   localparam int c_sym_last   = PAYLOAD_OFS + SYM_BYTES - 1;
   localparam int c_price_last = c_sym_last + PRICE_BYTES;

   parse_state_t           r_state;
   parse_state_t           w_next;
   logic [15:0]            r_cnt;
   logic [c_sw-1:0]        r_sym_sr;
   logic [c_pw-1:0]        r_price_sr;
   logic                   r_tready;

   logic                   w_hdr_ok;
   logic                   w_is_price_last;
   logic                   w_sym_shift;
   logic                   w_price_shift;
   logic                   w_price_last;
   logic                   w_drop;
   logic [c_pw-1:0]        w_price_full;
   logic [PRICE_OUT_W-1:0] w_price_sat;
   logic                   w_hit;
   logic [IDX_W-1:0]       w_hit_idx;

   assign s_axis.tready   = r_tready;
   assign w_hdr_ok        = hdr_byte_ok(r_cnt, s_axis.tdata, UDP_DPORT);
   assign w_is_price_last = (r_cnt == 16'(c_price_last));
   // The final price byte is still on the bus, so fold it in combinationally.
   assign w_price_full    = c_pw'({r_price_sr, s_axis.tdata});

   generate
      if (PRICE_OUT_W < c_pw) begin : g_sat
         assign w_price_sat = (|w_price_full[c_pw-1:PRICE_OUT_W]) ? '1
                                                                   : w_price_full[PRICE_OUT_W-1:0];
      end else begin : g_nosat
         assign w_price_sat = w_price_full[PRICE_OUT_W-1:0];
      end
   endgenerate

   udp_sym_cam #(
      .NUM_SYM   (NUM_SYM),
      .SYM_BYTES (SYM_BYTES),
      .IDX_W     (IDX_W)
   ) u_cam (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg_wr  (cfg_wr),
      .cfg_idx (cfg_idx),
      .cfg_sym (cfg_sym),
      .cfg_en  (cfg_en),
      .key     (r_sym_sr),
      .hit     (w_hit),
      .hit_idx (w_hit_idx)
   );

   // Parser state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_HDR;
      else        r_state <= w_next;
   end

   // Next state: only accepted bytes move the parser; tlast always rearms header parsing.
   always_comb begin
      w_next = r_state;
      if (s_axis.tvalid) begin
         if (s_axis.tlast) begin
            w_next = S_HDR;
         end else begin
            case (r_state)
               S_HDR: begin
                  if (!w_hdr_ok)                           w_next = S_DROP;
                  else if (r_cnt == 16'(PAYLOAD_OFS - 1))  w_next = S_SYM;
               end
               S_SYM:   if (r_cnt == 16'(c_sym_last)) w_next = S_PRICE;
               S_PRICE: if (w_is_price_last)          w_next = S_DROP;
               default: w_next = S_DROP;
            endcase
         end
      end
   end

   // Per-byte control strobes; a frame is dropped at most once (header miss or early tlast).
   always_comb begin
      w_sym_shift   = 1'b0;
      w_price_shift = 1'b0;
      w_price_last  = 1'b0;
      w_drop        = 1'b0;
      if (s_axis.tvalid) begin
         case (r_state)
            S_HDR:   w_drop = !w_hdr_ok || s_axis.tlast;
            S_SYM: begin
               w_sym_shift = 1'b1;
               w_drop      = s_axis.tlast;
            end
            S_PRICE: begin
               w_price_shift = 1'b1;
               w_price_last  = w_is_price_last;
               w_drop        = s_axis.tlast && !w_is_price_last;
            end
            default: ;
         endcase
      end
   end

   // Byte position within the frame; saturates so very long frames cannot alias the header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (s_axis.tvalid) begin
         if (s_axis.tlast)           r_cnt <= '0;
         else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
   end

   // Symbol and price shift registers, MSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sym_sr   <= '0;
         r_price_sr <= '0;
      end else begin
         if (w_sym_shift)   r_sym_sr   <= c_sw'({r_sym_sr, s_axis.tdata});
         if (w_price_shift) r_price_sr <= w_price_full;
      end
   end

   // Output stage: new price only on a table hit, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         price_valid <= 1'b0;
         price_out   <= '0;
         price_idx   <= '0;
      end else begin
         price_valid <= w_price_last && w_hit;
         if (w_price_last && w_hit) begin
            price_out <= w_price_sat;
            price_idx <= w_hit_idx;
         end
      end
   end

   // Dropped-packet counter, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              drop_cnt <= '0;
      else if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
   end

   // Ready rises on the first edge after reset and then stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tready <= 1'b0;
      else        r_tready <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_udp_md_parser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_udp_md_parser                                          |
// | Brief  : Randomised self-checking bench for udp_md_parser with a   |
// |          frame-level reference model.                              |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_udp_md_parser;

   localparam int          PL    = 49;   // last price byte index
   localparam logic [15:0] DPORT = 16'd5000;
   localparam logic [31:0] TSLA  = 32'h54534C41;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   udp_md_parser_if axis ();

   logic        cfg_wr  = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_sym = '0;
   logic        cfg_en  = 1'b0;
   logic [7:0]  price_out;
   logic [1:0]  price_idx;
   logic        price_valid;
   logic [15:0] drop_cnt;

   udp_md_parser #(
      .NUM_SYM(4), .SYM_BYTES(4), .PRICE_BYTES(4), .PRICE_OUT_W(8),
      .PAYLOAD_OFS(42), .UDP_DPORT(DPORT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_axis(axis),
      .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .cfg_en(cfg_en),
      .price_out(price_out), .price_idx(price_idx), .price_valid(price_valid),
      .drop_cnt(drop_cnt)
   );

   // ---------------- model state (written by the stimulus process) ----------------
   logic [7:0]  frame[$];
   logic [31:0] m_sym [4];
   logic        m_en  [4];
   int          m_drop = 0;
   logic [31:0] pool  [4];
   bit          last_emit;
   logic [7:0]  last_p;
   logic [1:0]  last_i;
   logic [7:0]  exp_p   [64];
   logic [1:0]  exp_i   [64];
   int          exp_due [64];
   int          exp_wr = 0;
   int          req_id = 0;
   int          req_code = 0;
   int          req_val = 0;
   bit          pin_emit;
   logic [7:0]  pin_p;
   logic [1:0]  pin_i;

   // ---------------- checker state (written by the compare process) ----------------
   int          total = 0;
   int          bad   = 0;
   int          exp_rd = 0;
   int          req_seen = 0;
   logic [7:0]  held_p = '0;
   logic [1:0]  held_i = '0;
   int          cyc = 0;
   int          rel = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rel <= rst_n ? rel + 1 : 0;

   // Single compare process: every output every cycle, plus requested checks.
   always @(negedge clk) begin
      bit ev;
      if (!rst_n) begin
         held_p = '0;
         held_i = '0;
         total++;
         if (price_valid !== 1'b0 || price_out !== 8'h00 || price_idx !== 2'd0 ||
             drop_cnt !== 16'h0 || axis.tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state valid=%b out=%h idx=%0d drop=%0d tready=%b, required all 0",
                     price_valid, price_out, price_idx, drop_cnt, axis.tready);
         end
      end else begin
         ev = (exp_rd != exp_wr) && (exp_due[exp_rd % 64] == cyc);
         if (ev) begin
            held_p = exp_p[exp_rd % 64];
            held_i = exp_i[exp_rd % 64];
            exp_rd++;
         end
         total++;
         if (price_valid !== ev || price_out !== held_p || price_idx !== held_i ||
             axis.tready !== (rel > 0)) begin
            bad++;
            $display("FAIL outputs cyc=%0d valid=%b/%b price=%h/%h idx=%0d/%0d tready=%b/%b (got/required)",
                     cyc, price_valid, ev, price_out, held_p, price_idx, held_i,
                     axis.tready, (rel > 0));
         end
         if (req_id != req_seen) begin
            req_seen = req_id;
            total++;
            case (req_code)
               1: if (drop_cnt !== 16'(m_drop)) begin
                     bad++;
                     $display("FAIL drop_cnt got=%0d required=%0d", drop_cnt, m_drop);
                  end
               2: if (last_emit !== pin_emit || (pin_emit && (last_p !== pin_p || last_i !== pin_i))) begin
                     bad++;
                     $display("FAIL model_pin emit=%b/%b price=%h/%h idx=%0d/%0d (got/required)",
                              last_emit, pin_emit, last_p, pin_p, last_i, pin_i);
                  end
               default: if (m_drop != req_val) begin
                     bad++;
                     $display("FAIL model_drop_pin got=%0d required=%0d", m_drop, req_val);
                  end
            endcase
         end
      end
   end

   // Frame-level reference: header fields, frame length, table lookup, saturation.
   task automatic model_eval(output bit drop, output bit emit,
                             output logic [7:0] p, output logic [1:0] ix);
      int          pos  [5];
      logic [7:0]  want [5];
      logic [31:0] sym, price;
      int          len;
      pos  = '{12, 13, 23, 36, 37};
      want = '{8'h08, 8'h00, 8'h11, DPORT[15:8], DPORT[7:0]};
      len  = frame.size();
      drop = 1'b0; emit = 1'b0; p = '0; ix = '0;
      for (int k = 0; k < 5; k++)
         if (pos[k] < len && frame[pos[k]] != want[k]) drop = 1'b1;
      if (!drop && len < PL + 1) drop = 1'b1;
      if (!drop) begin
         sym   = {frame[42], frame[43], frame[44], frame[45]};
         price = {frame[46], frame[47], frame[48], frame[49]};
         for (int k = 0; k < 4; k++)
            if (!emit && m_en[k] && m_sym[k] == sym) begin
               emit = 1'b1;
               ix   = 2'(k);
            end
         p = (price > 32'hFF) ? 8'hFF : price[7:0];
      end
   endtask

   task automatic build_frame(input int len, input logic [15:0] et, input logic [7:0] pr,
                              input logic [15:0] dp, input logic [31:0] sym, input logic [31:0] price);
      logic [7:0] b [70];
      for (int i = 0; i < 70; i++) b[i] = 8'($urandom);
      b[12] = et[15:8]; b[13] = et[7:0]; b[23] = pr;
      b[36] = dp[15:8]; b[37] = dp[7:0];
      for (int k = 0; k < 4; k++) begin
         b[42 + k] = sym[31 - 8*k -: 8];
         b[46 + k] = price[31 - 8*k -: 8];
      end
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(b[i]);
   endtask

   // gmode: 0 none, 1 random gaps, 2 three-cycle gaps before each price byte.
   task automatic send_frame(input int gmode, input bit cfg_last, input logic [1:0] cidx,
                             input logic [31:0] csym, input bit cen);
      bit drop, emit;
      logic [7:0] p;
      logic [1:0] ix;
      int gap;
      model_eval(drop, emit, p, ix);
      last_emit = emit; last_p = p; last_i = ix;
      if (drop && m_drop < 65535) m_drop++;
      for (int i = 0; i < frame.size(); i++) begin
         gap = 0;
         if (gmode == 1 && $urandom_range(0, 5) == 0) gap = $urandom_range(1, 3);
         if (gmode == 2 && i >= 46 && i <= PL)        gap = 3;
         repeat (gap) begin
            axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = 8'($urandom);
            @(posedge clk); #1;
         end
         axis.tvalid = 1'b1; axis.tdata = frame[i]; axis.tlast = (i == frame.size() - 1);
         if (i == PL && emit) begin
            exp_p[exp_wr % 64] = p; exp_i[exp_wr % 64] = ix; exp_due[exp_wr % 64] = cyc + 1;
            exp_wr++;
         end
         if (i == PL && cfg_last) begin
            cfg_wr = 1'b1; cfg_idx = cidx; cfg_sym = csym; cfg_en = cen;
         end
         @(posedge clk); #1;
         if (cfg_wr) begin
            cfg_wr = 1'b0; m_sym[cidx] = csym; m_en[cidx] = cen;
         end
      end
      axis.tvalid = 1'b0; axis.tlast = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [31:0] sym, input bit en);
      cfg_wr = 1'b1; cfg_idx = idx; cfg_sym = sym; cfg_en = en;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      m_sym[idx] = sym; m_en[idx] = en;
   endtask

   task automatic request(input int code, input int val);
      req_code = code; req_val = val; req_id++;
      @(posedge clk); #1;
   endtask

   task automatic pin(input bit e, input logic [7:0] p, input logic [1:0] ix);
      pin_emit = e; pin_p = p; pin_i = ix;
      request(2, 0);
   endtask

   initial begin
      int len;
      logic [15:0] et, dp;
      logic [7:0]  pr;
      logic [31:0] sym, price;
      pool = '{TSLA, 32'h4141504C, 32'h4D534654, 32'h474F4F47};
      for (int k = 0; k < 4; k++) begin m_sym[k] = '0; m_en[k] = 1'b0; end
      axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      cfg_write(2'd2, TSLA, 1'b1);

      // Basic price, then saturated price.
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h0000002A);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b1, 8'h2A, 2'd2);
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h00000300);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b1, 8'hFF, 2'd2);
      request(1, 0);

      // Wrong port, wrong EtherType.
      build_frame(60, 16'h0800, 8'h11, 16'd5001, TSLA, 32'h2A);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b0, 8'h00, 2'd0);
      request(3, 1);
      request(1, 0);
      build_frame(60, 16'h86DD, 8'h11, DPORT, TSLA, 32'h2A);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      request(3, 2);
      request(1, 0);

      // Short frame then back-to-back good frame.
      build_frame(48, 16'h0800, 8'h11, DPORT, TSLA, 32'h2A);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      build_frame(55, 16'h0800, 8'h11, DPORT, TSLA, 32'h00000077);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b1, 8'h77, 2'd2);
      request(3, 3);
      request(1, 0);

      // Disable entry 2 on the last price byte: this frame still hits, the next does not.
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h2A);
      send_frame(0, 1'b1, 2'd2, TSLA, 1'b0);
      pin(1'b1, 8'h2A, 2'd2);
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h2A);
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b0, 8'h00, 2'd0);
      request(1, 0);

      // Gaps inside the price field, duplicate symbol in entries 1 and 3.
      cfg_write(2'd1, TSLA, 1'b1);
      cfg_write(2'd3, TSLA, 1'b1);
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h0000002A);
      send_frame(2, 1'b0, 2'd0, '0, 1'b0);
      pin(1'b1, 8'h2A, 2'd1);

      // Randomised frames.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0)
            cfg_write(2'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
                      ($urandom_range(0, 3) != 0));
         len   = ($urandom_range(0, 9) < 7) ? $urandom_range(50, 70) : $urandom_range(10, 49);
         et    = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
         pr    = ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11;
         dp    = ($urandom_range(0, 7) == 0) ? DPORT + 16'($urandom_range(1, 100)) : DPORT;
         sym   = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 3)];
         price = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         build_frame(len, et, pr, dp, sym, price);
         send_frame(1, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                    pool[$urandom_range(0, 3)], ($urandom_range(0, 1) == 1));
         request(1, 0);
      end

      // Reset mid-frame: the tail is parsed as a new frame and dropped.
      build_frame(60, 16'h0800, 8'h11, DPORT, TSLA, 32'h2A);
      for (int i = 0; i < 30; i++) begin
         axis.tvalid = 1'b1; axis.tdata = frame[i]; axis.tlast = 1'b0;
         @(posedge clk); #1;
      end
      axis.tvalid = 1'b0;
      #2 rst_n = 1'b0;
      m_drop = 0;
      for (int k = 0; k < 4; k++) begin m_sym[k] = '0; m_en[k] = 1'b0; end
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) void'(frame.pop_front());
      send_frame(0, 1'b0, 2'd0, '0, 1'b0);
      request(3, 1);
      request(1, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
